// File: rtl/led_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg
// Shared definitions for the board status LED path.
//   - led_state_e : LED pattern states (also exported on state_o for debug)
//   - LED_TICK_DIV_DEFAULT : clk cycles per 1 kHz tick at 40 MHz
//   - LED_PWM_BITS_DEFAULT / LED_DIM_DEFAULT : default dimming frame setup
// -----------------------------------------------------------------------------
package led_pkg;

    typedef enum logic [1:0] {
        LED_OFF = 2'd0,
        LED_ON  = 2'd1,
        LED_ACT = 2'd2,
        LED_ERR = 2'd3
    } led_state_e;

    localparam int LED_TICK_DIV_DEFAULT = 40_000;
    localparam int LED_PWM_BITS_DEFAULT = 4;
    localparam int LED_DIM_DEFAULT      = 4;

endpackage : led_pkg

// File: rtl/led_tick_gen.sv
// -----------------------------------------------------------------------------
// led_tick_gen
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   tick  : high for exactly the cycle where the counter sits at TICK_DIV-1
// -----------------------------------------------------------------------------
module led_tick_gen
    import led_pkg::*;
#(
    parameter int TICK_DIV = LED_TICK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int            CW      = $clog2(TICK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [CW-1:0] r_tick_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
        end else if (r_tick_cnt == CNT_MAX) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + CNT_ONE;
        end
    end

    assign tick = (r_tick_cnt == CNT_MAX);

endmodule : led_tick_gen

// File: rtl/led_status_driver.sv
// -----------------------------------------------------------------------------
// led_status_driver
// Final LED stage: picks off / steady on / activity flicker / error blink by
// priority and applies optional PWM dimming before the registered LED pin.
// Ports:
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   slow_blink : clk-synchronous square wave, shown while in error
//   link_up    : asynchronous level, 2-flop synchronised
//   err        : asynchronous level, 2-flop synchronised
//   act_stb    : clk-synchronous single-cycle activity strobe
//   dim_en     : 1 = gate the LED with the PWM frame
//   led        : registered LED drive
//   state_o    : current pattern state (debug)
// -----------------------------------------------------------------------------
module led_status_driver
    import led_pkg::*;
#(
    parameter int                TICK_DIV       = LED_TICK_DIV_DEFAULT,
    parameter int                ACT_HOLD_TICKS = 50,
    parameter int                ACT_HALF_TICKS = 25,
    parameter int                PWM_BITS       = LED_PWM_BITS_DEFAULT,
    parameter logic [PWM_BITS:0] DIM            = (PWM_BITS + 1)'(LED_DIM_DEFAULT)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       slow_blink,
    input  logic       link_up,
    input  logic       err,
    input  logic       act_stb,
    input  logic       dim_en,
    output logic       led,
    output logic [1:0] state_o
);

    localparam int                  HW        = $clog2(ACT_HOLD_TICKS + 1);
    localparam int                  FW        = $clog2(ACT_HALF_TICKS + 1);
    localparam logic [HW-1:0]       HOLD_LOAD = HW'(ACT_HOLD_TICKS);
    localparam logic [HW-1:0]       HOLD_ONE  = HW'(1);
    localparam logic [FW-1:0]       HALF_LAST = FW'(ACT_HALF_TICKS - 1);
    localparam logic [FW-1:0]       HALF_ONE  = FW'(1);
    localparam logic [PWM_BITS-1:0] PWM_ONE   = PWM_BITS'(1);

    logic [1:0]          r_sync1;      // [1]=err, [0]=link_up
    logic [1:0]          r_sync2;
    logic [HW-1:0]       r_hold_cnt;
    logic [FW-1:0]       r_half_cnt;
    logic                r_fast_phase;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    led_state_e          r_state;
    logic                r_led;

    logic w_tick;
    logic w_link_s;
    logic w_err_s;
    logic w_raw;
    logic w_gate;

    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_tick)
    );

    // Two-flop synchronisers for the asynchronous status levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {err, link_up};
            r_sync2 <= r_sync1;
        end
    end

    assign w_link_s = r_sync2[0];
    assign w_err_s  = r_sync2[1];

    // Activity hold. Link loss dominates; a fresh strobe beats a tick
    // decrement in the same cycle so a retrigger always yields a full hold.
    // Error does not block loading, so the hold keeps running underneath ERR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_cnt <= '0;
        end else if (!w_link_s) begin
            r_hold_cnt <= '0;
        end else if (act_stb) begin
            r_hold_cnt <= HOLD_LOAD;
        end else if (w_tick && (r_hold_cnt != '0)) begin
            r_hold_cnt <= r_hold_cnt - HOLD_ONE;
        end
    end

    // Flicker phase is parked at 0 outside ACT, so every entry into ACT
    // starts with the LED dark and the first half-period is a full one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_half_cnt   <= '0;
            r_fast_phase <= 1'b0;
        end else if (r_state != LED_ACT) begin
            r_half_cnt   <= '0;
            r_fast_phase <= 1'b0;
        end else if (w_tick) begin
            if (r_half_cnt == HALF_LAST) begin
                r_half_cnt   <= '0;
                r_fast_phase <= ~r_fast_phase;
            end else begin
                r_half_cnt <= r_half_cnt + HALF_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_ONE;
        end
    end

    always_comb begin
        w_raw = 1'b0;
        case (r_state)
            LED_OFF: w_raw = 1'b0;
            LED_ON:  w_raw = 1'b1;
            LED_ACT: w_raw = r_fast_phase;
            LED_ERR: w_raw = slow_blink;
            default: w_raw = 1'b0;
        endcase
    end

    // DIM is one bit wider than the counter so 2^PWM_BITS means always on.
    assign w_gate = !dim_en || ({1'b0, r_pwm_cnt} < DIM);

    // Pattern FSM with strict priority err > link down > activity > on,
    // plus the registered LED output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LED_OFF;
            r_led   <= 1'b0;
        end else begin
            if (w_err_s) begin
                r_state <= LED_ERR;
            end else if (!w_link_s) begin
                r_state <= LED_OFF;
            end else if (r_hold_cnt != '0) begin
                r_state <= LED_ACT;
            end else begin
                r_state <= LED_ON;
            end
            r_led <= w_raw & w_gate;
        end
    end

    assign led     = r_led;
    assign state_o = r_state;

endmodule : led_status_driver

// File: tb/tb_led_status_driver.sv
// -----------------------------------------------------------------------------
// tb_led_status_driver
// Directed bench for led_status_driver with TICK_DIV=4, ACT_HOLD_TICKS=3,
// ACT_HALF_TICKS=1, PWM_BITS=2. The main instance uses DIM=1; two extra
// instances sharing the same inputs use DIM=0 and DIM=4 for the dimming
// boundaries. cyc counts clock edges since the last reset release, so
// cyc%4==0 marks the edges where a tick is consumed and cyc%4 is also the
// PWM count seen before edge cyc+1.
// -----------------------------------------------------------------------------
module tb_led_status_driver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       slow_blink;
    logic       link_up;
    logic       err;
    logic       act_stb;
    logic       dim_en;
    logic       led;
    logic [1:0] state_o;
    logic       led_d0;
    logic [1:0] st_d0;
    logic       led_d4;
    logic [1:0] st_d4;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // LED after edges k+1..k+13 for a single strobe loaded at edge k (k%4==1)
    logic [1:13] exp_led_seq = 13'b1001111000011;
    logic [4:0]  sb_pat      = 5'b11010;

    always #5 clk = ~clk;

    led_status_driver #(
        .TICK_DIV(4), .ACT_HOLD_TICKS(3), .ACT_HALF_TICKS(1), .PWM_BITS(2), .DIM(3'd1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .slow_blink(slow_blink), .link_up(link_up),
        .err(err), .act_stb(act_stb), .dim_en(dim_en), .led(led), .state_o(state_o)
    );

    led_status_driver #(
        .TICK_DIV(4), .ACT_HOLD_TICKS(3), .ACT_HALF_TICKS(1), .PWM_BITS(2), .DIM(3'd0)
    ) dut_dim0 (
        .clk(clk), .rst_n(rst_n), .slow_blink(slow_blink), .link_up(link_up),
        .err(err), .act_stb(act_stb), .dim_en(dim_en), .led(led_d0), .state_o(st_d0)
    );

    led_status_driver #(
        .TICK_DIV(4), .ACT_HOLD_TICKS(3), .ACT_HALF_TICKS(1), .PWM_BITS(2), .DIM(3'd4)
    ) dut_dim4 (
        .clk(clk), .rst_n(rst_n), .slow_blink(slow_blink), .link_up(link_up),
        .err(err), .act_stb(act_stb), .dim_en(dim_en), .led(led_d4), .state_o(st_d4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d (cyc=%0d)", tag, got, want, cyc);
        end
        $display("chk %-16s cyc=%0d obs=%0d exp=%0d", tag, cyc, got, want);
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // Step until cyc%4==p (at most 3 steps).
    task automatic align(input int p);
        for (int i = 0; i < 4; i++) begin
            if (cyc % 4 != p) step();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; slow_blink = 1'b0; link_up = 1'b0; err = 1'b0;
        act_stb = 1'b0; dim_en = 1'b0;
        #12;
        check("reset_led", led, 0);
        check("reset_state", state_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;

        // Link bring-up: link_up sampled at edge k=3
        step(); step();
        check("idle_state", state_o, 0);
        check("idle_led", led, 0);
        link_up = 1'b1;
        step();                                   // k
        check("link_k", state_o, 0);
        step();                                   // k+1
        check("link_k1", state_o, 0);
        step();                                   // k+2
        check("link_k2_state", state_o, 1);
        check("link_k2_led", led, 0);
        step();                                   // k+3
        check("link_k3_led", led, 1);

        // Single strobe loaded at k (k%4==1)
        align(0);
        act_stb = 1'b1; step(); act_stb = 1'b0;   // k
        check("act_load_state", state_o, 1);
        for (int i = 1; i <= 13; i++) begin
            step();
            check("act_led", led, exp_led_seq[i]);
            check("act_state", state_o, (i <= 11) ? 2 : 1);
        end

        // Retrigger at k+5 restarts the hold: ACT through k+15, ON at k+16
        align(0);
        act_stb = 1'b1; step(); act_stb = 1'b0;   // k
        for (int i = 0; i < 4; i++) step();       // k+4
        act_stb = 1'b1; step(); act_stb = 1'b0;   // k+5
        for (int i = 0; i < 10; i++) step();      // k+15
        check("retrig_hold", state_o, 2);
        step();                                   // k+16
        check("retrig_end", state_o, 1);

        // Strobe on a tick edge loads 3: ACT at k+12, ON at k+13
        align(3);
        act_stb = 1'b1; step(); act_stb = 1'b0;   // k (tick edge)
        for (int i = 0; i < 12; i++) step();      // k+12
        check("tick_coinc_act", state_o, 2);
        step();                                   // k+13
        check("tick_coinc_on", state_o, 1);
        step();
        check("tick_coinc_led", led, 1);

        // Error during ACT
        align(0);
        act_stb = 1'b1; step(); act_stb = 1'b0;   // k
        step(); step();                           // k+2
        err = 1'b1;
        step(); step();                           // k+4
        check("err_pre", state_o, 2);
        step();                                   // k+5
        check("err_state", state_o, 3);
        for (int i = 4; i >= 0; i--) begin
            slow_blink = sb_pat[i];
            step();
            check("err_blink", led, sb_pat[i]);
        end
        slow_blink = 1'b0;
        step(); step();                           // k+12, hold expired at k+11
        check("err_hold", state_o, 3);
        err = 1'b0;
        step(); step();                           // k+14
        check("err_still", state_o, 3);
        step();                                   // k+15
        check("err_clear_state", state_o, 1);
        step();
        check("err_clear_led", led, 1);

        // Link down latency, then strobes while link is down
        link_up = 1'b0;
        step();                                   // k
        check("linkdn_k", state_o, 1);
        step();                                   // k+1
        check("linkdn_k1_state", state_o, 1);
        check("linkdn_k1_led", led, 1);
        step();                                   // k+2
        check("linkdn_k2_state", state_o, 0);
        check("linkdn_k2_led", led, 1);
        step();                                   // k+3
        check("linkdn_k3_led", led, 0);
        act_stb = 1'b1; step(); act_stb = 1'b0;
        check("linkdn_stb_state", state_o, 0);
        check("linkdn_stb_led", led, 0);
        act_stb = 1'b1; step(); act_stb = 1'b0;  // j
        link_up = 1'b1;
        step(); step(); step();                   // j+3
        check("linkdn_no_hold", state_o, 1);
        step();
        check("linkup_led", led, 1);
        check("dim4_state", st_d4, 1);
        check("dim0_state", st_d0, 1);

        // Dimming in ON
        dim_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("dim1_led", led, (cyc % 4 == 1) ? 1 : 0);
            check("dim0_led", led_d0, 0);
            check("dim4_led", led_d4, 1);
        end
        dim_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("nodim_led", led, 1);
        end

        // Asynchronous reset while in ACT with the LED lit
        align(0);
        act_stb = 1'b1; step(); act_stb = 1'b0;   // k
        for (int i = 0; i < 4; i++) step();       // k+4
        check("pre_rst_led", led, 1);
        check("pre_rst_state", state_o, 2);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_led", led, 0);
        check("async_rst_state", state_o, 0);
        step();
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        for (int i = 1; i <= 3; i++) begin
            step();
            check("rel_led_low", led, 0);
        end
        check("rel_state_on", state_o, 1);
        step();
        check("rel_led_4th", led, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_led_status_driver
